// File: rtl/logdrain_pkg.sv
// Shared types and constants for the logdrain log-buffer drain engine.
// The optional newline terminator is enabled with LOGDRAIN_NL_EN (see logdrain.sv).
package logdrain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_IX,
        RD_SLOT,
        EMIT,
        EMIT_NL,
        WR_IX,
        FIN
    } state_t;

    localparam logic       ADDR_DATA  = 1'b0;
    localparam logic       ADDR_INDEX = 1'b1;
    localparam logic [7:0] NL_BYTE    = 8'h0A;

    localparam int PUT_MSB = 31;
    localparam int PUT_LSB = 16;
    localparam int GET_MSB = 15;
    localparam int GET_LSB = 0;

    // Read index advances modulo the number of entries in the buffer.
    function automatic logic [15:0] nextIndex(input logic [15:0] ix, input int numEntries);
        logic [15:0] last;
        last = 16'(numEntries - 1);
        return (ix == last) ? 16'd0 : ix + 16'd1;
    endfunction

endpackage

// File: rtl/logdrain_bus.sv
// Single-access bus sequencer: a one-cycle request raises stb, held until ack,
// then a one-cycle completion pulse presents the data captured on the ack cycle.
module logdrain_bus
    import logdrain_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic        i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_ack,
    input  logic [31:0] i_din,
    output logic        o_stb,
    output logic        o_we,
    output logic        o_addr,
    output logic [31:0] o_dout,
    output logic        o_done,
    output logic [31:0] o_rdata
);

    logic        r_stb;
    logic        r_we;
    logic        r_addr;
    logic [31:0] r_dout;
    logic        r_done;
    logic [31:0] r_rdata;

    // stb falls on the ack edge, so consecutive accesses always have a gap cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= ADDR_DATA;
            r_dout  <= 32'd0;
            r_done  <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (r_stb) begin
                if (i_ack) begin
                    r_stb   <= 1'b0;
                    r_we    <= 1'b0;
                    r_addr  <= ADDR_DATA;
                    r_done  <= 1'b1;
                    r_rdata <= i_din;
                end
            end else if (i_req) begin
                r_stb  <= 1'b1;
                r_we   <= i_we;
                r_addr <= i_addr;
                r_dout <= i_wdata;
            end
        end
    end

    assign o_stb   = r_stb;
    assign o_we    = r_we;
    assign o_addr  = r_addr;
    assign o_dout  = r_dout;
    assign o_done  = r_done;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/logdrain.sv
// Autonomous log-buffer drain: streams every slot byte of each pending entry, then
// writes back the advanced read index. Define LOGDRAIN_NL_EN to append 0x0A per entry.
module logdrain
    import logdrain_pkg::*;
#(
    parameter int NUM_ENTRIES = 32,
    parameter int ENTRY_SLOTS = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_stb,
    output logic        o_we,
    output logic        o_addr,
    output logic [31:0] o_dout,
    input  logic [31:0] i_din,
    input  logic        i_ack,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready
);

    localparam int SLOT_W = $clog2(ENTRY_SLOTS + 1);

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_req;
    logic                r_reqWe;
    logic                r_reqAddr;
    logic [31:0]         r_reqData;
    logic [15:0]         r_put;
    logic [15:0]         r_get;
    logic [SLOT_W-1:0]   r_slot;
    logic [7:0]          r_txData;
    logic                r_txValid;

    logic                w_busDone;
    logic [31:0]         w_busData;
    logic [SLOT_W-1:0]   w_slotNext;

    assign w_slotNext = r_slot + 1'b1;

    logdrain_bus u_bus (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (r_req),
        .i_we    (r_reqWe),
        .i_addr  (r_reqAddr),
        .i_wdata (r_reqData),
        .i_ack   (i_ack),
        .i_din   (i_din),
        .o_stb   (o_stb),
        .o_we    (o_we),
        .o_addr  (o_addr),
        .o_dout  (o_dout),
        .o_done  (w_busDone),
        .o_rdata (w_busData)
    );

    // Each bus state issues a one-cycle request on entry and waits for completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_req     <= 1'b0;
            r_reqWe   <= 1'b0;
            r_reqAddr <= ADDR_DATA;
            r_reqData <= 32'd0;
            r_put     <= 16'd0;
            r_get     <= 16'd0;
            r_slot    <= '0;
            r_txData  <= 8'd0;
            r_txValid <= 1'b0;
        end else begin
            r_req  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_busy    <= 1'b1;
                        r_state   <= RD_IX;
                        r_req     <= 1'b1;
                        r_reqWe   <= 1'b0;
                        r_reqAddr <= ADDR_INDEX;
                    end
                end
                RD_IX: begin
                    if (w_busDone) begin
                        r_put <= w_busData[PUT_MSB:PUT_LSB];
                        r_get <= w_busData[GET_MSB:GET_LSB];
                        if (w_busData[PUT_MSB:PUT_LSB] == w_busData[GET_MSB:GET_LSB]) begin
                            r_state <= FIN;
                        end else begin
                            r_slot    <= '0;
                            r_state   <= RD_SLOT;
                            r_req     <= 1'b1;
                            r_reqWe   <= 1'b0;
                            r_reqAddr <= ADDR_DATA;
                        end
                    end
                end
                RD_SLOT: begin
                    if (w_busDone) begin
                        r_txData  <= w_busData[7:0];
                        r_txValid <= 1'b1;
                        r_state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (i_tx_ready) begin
                        r_txValid <= 1'b0;
                        r_slot    <= w_slotNext;
                        if (w_slotNext == SLOT_W'(ENTRY_SLOTS)) begin
`ifdef LOGDRAIN_NL_EN
                            r_txData  <= NL_BYTE;
                            r_txValid <= 1'b1;
                            r_state   <= EMIT_NL;
`else
                            r_state   <= WR_IX;
                            r_req     <= 1'b1;
                            r_reqWe   <= 1'b1;
                            r_reqAddr <= ADDR_INDEX;
                            r_reqData <= {r_put, nextIndex(r_get, NUM_ENTRIES)};
`endif
                        end else begin
                            r_state   <= RD_SLOT;
                            r_req     <= 1'b1;
                            r_reqWe   <= 1'b0;
                            r_reqAddr <= ADDR_DATA;
                        end
                    end
                end
`ifdef LOGDRAIN_NL_EN
                EMIT_NL: begin
                    if (i_tx_ready) begin
                        r_txValid <= 1'b0;
                        r_state   <= WR_IX;
                        r_req     <= 1'b1;
                        r_reqWe   <= 1'b1;
                        r_reqAddr <= ADDR_INDEX;
                        r_reqData <= {r_put, nextIndex(r_get, NUM_ENTRIES)};
                    end
                end
`endif
                WR_IX: begin
                    // Re-read the indices so entries logged during the drain are picked up.
                    if (w_busDone) begin
                        r_state   <= RD_IX;
                        r_req     <= 1'b1;
                        r_reqWe   <= 1'b0;
                        r_reqAddr <= ADDR_INDEX;
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_tx_data  = r_txData;
    assign o_tx_valid = r_txValid;

endmodule

// File: tb/tb_logdrain.sv
// Self-checking bench for logdrain: a behavioural log buffer on the private port,
// a stallable byte sink, table-driven drain scenarios and a mid-drain reset sequence.
module tb_logdrain;

`ifdef LOGDRAIN_NL_EN
    localparam int BPE = 65;
`else
    localparam int BPE = 64;
`endif
    localparam int SLOTS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        stb;
    logic        we;
    logic        addr;
    logic [31:0] dout;
    logic [31:0] din;
    logic        ack;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;

    logic [31:0] idxReg;
    int          slotPtr;
    logic        presetReq;
    logic [31:0] presetVal;
    int          stall;
    int          waitCnt;

    logic [7:0]  rxBytes[$];
    logic [31:0] wrLog[$];
    int          idxReads;
    int          dataReads;
    int          stabErr;
    int          busErr;
    logic        prevValid;
    logic        prevHs;
    logic [7:0]  prevData;
    logic        prevAcc;

    int          testsRun;
    int          testsFailed;

    logdrain dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .o_busy     (busy),
        .o_done     (done),
        .o_stb      (stb),
        .o_we       (we),
        .o_addr     (addr),
        .o_dout     (dout),
        .i_din      (din),
        .i_ack      (ack),
        .o_tx_data  (txData),
        .o_tx_valid (txValid),
        .i_tx_ready (txReady)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byteOf(input logic [15:0] e, input int s);
        int v;
        v = int'(e) * 3 + s + 64;
        return v[7:0];
    endfunction

    function automatic logic [15:0] wrapNext(input logic [15:0] e);
        return (e == 16'd31) ? 16'd0 : e + 16'd1;
    endfunction

    // Log buffer model: same-cycle ack, data reads walk the slot pointer of entry get.
    assign ack = stb;
    always_comb begin
        din = 32'd0;
        if (addr) din = idxReg;
        else      din = {24'd0, byteOf(idxReg[15:0], slotPtr)};
    end
    always_comb txReady = (stall == 0) || (waitCnt >= stall);

    always @(posedge clk) begin
        if (presetReq) begin
            idxReg  <= presetVal;
            slotPtr <= 0;
        end else if (stb && ack) begin
            if (addr) begin
                if (we) idxReg <= dout;
                else    slotPtr <= 0;
            end else begin
                slotPtr <= slotPtr + 1;
            end
        end
        if (txValid && txReady) waitCnt <= 0;
        else if (txValid)       waitCnt <= waitCnt + 1;
        else                    waitCnt <= 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            prevValid <= 1'b0;
            prevHs    <= 1'b0;
            prevData  <= 8'd0;
            prevAcc   <= 1'b0;
        end else begin
            if (txValid && txReady) rxBytes.push_back(txData);
            if (stb && ack) begin
                if (addr) begin
                    if (we) wrLog.push_back(dout);
                    else    idxReads <= idxReads + 1;
                end else begin
                    dataReads <= dataReads + 1;
                end
            end
            if (prevValid && !prevHs && (!txValid || txData != prevData)) stabErr <= stabErr + 1;
            if (prevAcc && stb) busErr <= busErr + 1;
            prevValid <= txValid;
            prevHs    <= txValid && txReady;
            prevData  <= txData;
            prevAcc   <= stb && ack;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic presetIndex(input logic [15:0] put, input logic [15:0] get);
        @(negedge clk);
        presetVal = {put, get};
        presetReq = 1'b1;
        @(negedge clk);
        presetReq = 1'b0;
    endtask

    task automatic waitDone(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] put;
        logic [15:0] get;
        int          stall;
        int          entries;
        int          expIdxReads;
        logic [31:0] expFinal;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic        ok;
        int          rx0, w0, ir0, dr0, st0, bu0;
        int          n, wi, byteErrs, wrErrs;
        logic [15:0] e, ne;
        logic [7:0]  expByte;

        testsRun    = 0;
        testsFailed = 0;
        idxReads    = 0;
        dataReads   = 0;
        stabErr     = 0;
        busErr      = 0;
        start       = 1'b0;
        presetReq   = 1'b0;
        presetVal   = 32'd0;
        stall       = 0;
        rst         = 1'b1;

        vecs[0] = '{put: 16'd3,  get: 16'd3,  stall: 0, entries: 0, expIdxReads: 1, expFinal: 32'h0003_0003};
        vecs[1] = '{put: 16'd1,  get: 16'd0,  stall: 0, entries: 1, expIdxReads: 2, expFinal: 32'h0001_0001};
        vecs[2] = '{put: 16'd1,  get: 16'd31, stall: 0, entries: 2, expIdxReads: 3, expFinal: 32'h0001_0001};
        vecs[3] = '{put: 16'd5,  get: 16'd4,  stall: 5, entries: 1, expIdxReads: 2, expFinal: 32'h0005_0005};
        vecs[4] = '{put: 16'd10, get: 16'd7,  stall: 1, entries: 3, expIdxReads: 4, expFinal: 32'h000A_000A};

        repeat (3) @(negedge clk);
        checkOutput("resetCtrl", {31'd0, busy} | {31'd0, done} | {31'd0, stb} | {31'd0, we} |
                    {31'd0, addr} | {31'd0, txValid}, 32'd0);
        checkOutput("resetDout", dout, 32'd0);
        checkOutput("resetTxData", {24'd0, txData}, 32'd0);
        rst = 1'b0;
        presetIndex(16'd0, 16'd0);

        for (int i = 0; i < 5; i++) begin
            presetIndex(vecs[i].put, vecs[i].get);
            stall = vecs[i].stall;
            rx0 = rxBytes.size(); w0 = wrLog.size();
            ir0 = idxReads; dr0 = dataReads; st0 = stabErr; bu0 = busErr;
            applyStimulus();
            waitDone(ok);
            checkOutput($sformatf("v%0d.done", i), {31'd0, ok}, 32'd1);

            e = vecs[i].get; n = 0; wi = 0; byteErrs = 0; wrErrs = 0;
            while (e != vecs[i].put) begin
                ne = wrapNext(e);
                for (int s = 0; s < BPE; s++) begin
                    expByte = (s == SLOTS) ? 8'h0A : byteOf(e, s);
                    if (rx0 + n >= rxBytes.size() || rxBytes[rx0 + n] != expByte) byteErrs++;
                    n++;
                end
                if (w0 + wi >= wrLog.size() || wrLog[w0 + wi] != {vecs[i].put, ne}) wrErrs++;
                wi++;
                e = ne;
            end
            checkOutput($sformatf("v%0d.byteCount", i), 32'(rxBytes.size() - rx0), 32'(vecs[i].entries * BPE));
            checkOutput($sformatf("v%0d.byteOrder", i), 32'(byteErrs), 32'd0);
            checkOutput($sformatf("v%0d.writeCount", i), 32'(wrLog.size() - w0), 32'(vecs[i].entries));
            checkOutput($sformatf("v%0d.writeValues", i), 32'(wrErrs), 32'd0);
            checkOutput($sformatf("v%0d.finalIndex", i), idxReg, vecs[i].expFinal);
            checkOutput($sformatf("v%0d.dataReads", i), 32'(dataReads - dr0), 32'(vecs[i].entries * SLOTS));
            checkOutput($sformatf("v%0d.indexReads", i), 32'(idxReads - ir0), 32'(vecs[i].expIdxReads));
            checkOutput($sformatf("v%0d.txStable", i), 32'(stabErr - st0), 32'd0);
            checkOutput($sformatf("v%0d.stbGap", i), 32'(busErr - bu0), 32'd0);
            checkOutput($sformatf("v%0d.busyIdle", i), {31'd0, busy}, 32'd0);
        end

        // Reset after ten bytes of an entry: everything clears, no write-back occurs.
        presetIndex(16'd1, 16'd0);
        stall = 0;
        rx0 = rxBytes.size(); w0 = wrLog.size();
        applyStimulus();
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (rxBytes.size() - rx0 >= 10) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("midReset.reached10", {31'd0, ok}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midReset.ctrl", {26'd0, busy, done, stb, we, addr, txValid}, 32'd0);
        checkOutput("midReset.data", dout | {24'd0, txData}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midReset.noWrite", 32'(wrLog.size() - w0), 32'd0);
        checkOutput("midReset.indexKept", idxReg, 32'h0001_0000);

        // Restart re-emits from slot 0; a second start while busy must not queue a drain.
        rx0 = rxBytes.size(); ir0 = idxReads; bu0 = busErr;
        applyStimulus();
        for (int c = 0; c < 2000; c++) begin
            if (rxBytes.size() - rx0 >= 3) break;
            @(negedge clk);
        end
        applyStimulus();
        waitDone(ok);
        checkOutput("restart.done", {31'd0, ok}, 32'd1);
        checkOutput("restart.byteCount", 32'(rxBytes.size() - rx0), 32'(BPE));
        byteErrs = 0;
        for (int s = 0; s < BPE && rx0 + s < rxBytes.size(); s++) begin
            expByte = (s == SLOTS) ? 8'h0A : byteOf(16'd0, s);
            if (rxBytes[rx0 + s] != expByte) byteErrs++;
        end
        checkOutput("restart.byteOrder", 32'(byteErrs), 32'd0);
        checkOutput("restart.lastByte", {24'd0, rxBytes[rxBytes.size() - 1]},
                    (BPE == 65) ? 32'h0A : 32'h7F);
        checkOutput("restart.indexReads", 32'(idxReads - ir0), 32'd2);
        checkOutput("restart.finalIndex", idxReg, 32'h0001_0001);
        checkOutput("restart.stbGap", 32'(busErr - bu0), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("restart.noRequeue", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/logdrain.md
Name: logdrain

Overview:
- Bus initiator that empties the log buffer autonomously.
- On `start` it reads the index register and drains each pending entry, one slot byte at a time.
- It presents the bytes on a valid/ready byte stream (typically the RS232 transmitter), then writes back the advanced read index.
- Sits beside the log buffer on a private port; arbitration against CPU access is outside this block.

Parameters:
- NUM_ENTRIES, 32, number of entries in the log buffer; read index wraps modulo this.
- ENTRY_SLOTS, 64, bytes per entry; all are emitted, none skipped.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to drain; ignored while busy
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when drain ends
- stb  out  1  bus strobe
- we  out  1  bus write enable
- addr  out  1  0 = log data, 1 = indices
- dout  out  32  write data to log buffer
- din  in  32  read data from log buffer
- ack  in  1  bus acknowledge (log buffer returns ack = stb, same cycle)
- tx_data  out  8  stream byte
- tx_valid  out  1  stream byte valid
- tx_ready  in  1  sink accepts byte when valid & ready

Behaviour:
- Reset: state IDLE; busy, done, stb, we, addr, tx_valid = 0; dout, tx_data = 0; internal put/get/slot counters = 0. Reset mid-drain aborts immediately with no index write-back.
- Bus rule: stb is held until ack. Each cycle with stb & ack counts as exactly one access, and din is sampled in that cycle. stb drops for at least one cycle between accesses, so one ack advances the log-buffer slot pointer exactly once.
- Index format: din = {put_ix[15:0], get_ix[15:0]}.
- IDLE: when start arrives, set busy and go to RD_IX.
- RD_IX: stb=1, we=0, addr=1. On ack, latch put and get. This read also resets the entry slot pointer.
  - If get == put, go to FIN.
  - Otherwise clear slot counter and go to RD_SLOT.
- RD_SLOT: stb=1, we=0, addr=0. On ack, capture din[7:0] into tx_data, set tx_valid, go to EMIT.
- EMIT: hold tx_data and tx_valid stable until tx_ready.
  - On handshake, drop tx_valid and increment the slot counter.
  - If counter == ENTRY_SLOTS, go to WR_IX; else go to RD_SLOT.
  - If tx_ready is already high on the first valid cycle, the byte transfers in that cycle.
- WR_IX: stb=1, we=1, addr=1, dout = {put, next_get}, where next_get = get+1, or 0 when get == NUM_ENTRIES-1.
  - On ack, return to RD_IX. Re-reading picks up entries added meanwhile.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Full buffer: index values are taken as given; no overflow check here.
- Widths: slot counter $clog2(ENTRY_SLOTS+1) bits. Index arithmetic 16 bits, compared against NUM_ENTRIES-1.
- Throughput: at most one byte per 2 cycles (RD_SLOT + EMIT). Entry overhead is 2 bus accesses.
- start while busy: ignored, not queued.

Optional Feature:
- LOGDRAIN_NL_EN defined: after the last slot of each entry, an extra state EMIT_NL sends byte 0x0A through the same handshake before WR_IX. Each entry then produces ENTRY_SLOTS+1 stream bytes.
- Undefined: exactly ENTRY_SLOTS bytes per entry; EMIT_NL state absent.

Decomposition:
- Shared package: FSM state enum (IDLE, RD_IX, RD_SLOT, EMIT, EMIT_NL, WR_IX, FIN); constants ADDR_DATA=0, ADDR_INDEX=1, NL_BYTE=8'h0A; index field positions (put 31:16, get 15:0).
- One natural sub-module, logdrain_bus: single-access bus sequencer (req in; stb/we/addr out; held until ack; completion pulse with captured din). FSM instantiates it once.

Test Plan:
- Empty buffer: index reads 0x0003_0003, start -> no data reads, no tx_valid, done pulses after one index read.
- One entry: put=1, get=0, slot bytes 0..63 = 0x40..0x7F, tx_ready=1 -> stream 0x40..0x7F in order. Then write 0x0001_0001, re-read index, done.
- Wrap: NUM_ENTRIES=32, get=31, put=1 -> entries 31 and 0 drained. Write-backs 0x0001_0000 then 0x0001_0001.
- Backpressure: tx_ready low 5 cycles per byte -> tx_data stable while valid, no extra data reads (exactly 64 per entry), byte order intact.
- Reset mid-entry (after 10 bytes) -> all outputs 0 next cycle, no index write. Subsequent start re-reads index and re-emits the entry from slot 0.
- With LOGDRAIN_NL_EN: single entry -> 65 bytes, last = 0x0A. Without it: 64 bytes.
